// File: rtl/spi_regs_pkg.sv
// Register map, CTRL bit positions and sequencer states for the SPI core driver.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package spi_regs_pkg;

  // Byte addresses of the SPI core registers on its Wishbone slave port
  localparam logic [4:0] ADDR_RX0  = 5'h00;
  localparam logic [4:0] ADDR_TX0  = 5'h00;
  localparam logic [4:0] ADDR_CTRL = 5'h10;
  localparam logic [4:0] ADDR_DIV  = 5'h14;
  localparam logic [4:0] ADDR_SS   = 5'h18;

  // CTRL register bit positions
  localparam int CTRL_GO           = 8;
  localparam int CTRL_RX_NEG       = 9;
  localparam int CTRL_TX_NEG       = 10;
  localparam int CTRL_LSB          = 11;
  localparam int CTRL_IE           = 12;
  localparam int CTRL_ASS          = 13;
  localparam int CTRL_CHAR_LEN_MSB = 6;
  localparam int CTRL_CHAR_LEN_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DIV,
    S_WR_SS,
    S_WR_TX,
    S_WR_CTRL,
    S_POLL,
    S_RD_RX,
    S_RSP
  } seq_state_t;

  // CTRL word that starts a transfer: mode bits, GO set, bit 7 clear, char_len
  function automatic logic [31:0] ctrl_word(input logic [4:0] mode, input logic [6:0] len);
    ctrl_word = {18'd0, mode, 1'b1, 1'b0, len};
  endfunction

endpackage

// File: rtl/spi_wbm_xfer.sv
// Single Wishbone master transfer engine: latches one request on start, drives cyc/stb until ack.
// Latency: bus asserts the cycle after start; done pulses combinationally with the sampled ack.
// Backpressure: unbounded ack wait; start is ignored while a transfer is open, bus idles one cycle after ack.
module spi_wbm_xfer (
  input  logic        wb_clk_in,
  input  logic        wb_rst_in,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_sel,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_wbm_cyc,
  output logic        o_wbm_stb,
  output logic        o_wbm_we,
  output logic [4:0]  o_wbm_addr,
  output logic [31:0] o_wbm_data,
  output logic [3:0]  o_wbm_sel,
  input  logic [31:0] i_wbm_data,
  input  logic        i_wbm_ack
);

  logic        r_cyc;
  logic        r_we;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_sel;

  // Open a cycle on start, close it (clearing every bus output) on the ack edge
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_sel  <= '0;
    end else if (r_cyc) begin
      if (i_wbm_ack) begin
        r_cyc  <= 1'b0;
        r_we   <= 1'b0;
        r_addr <= '0;
        r_data <= '0;
        r_sel  <= '0;
      end
    end else if (i_start) begin
      r_cyc  <= 1'b1;
      r_we   <= i_we;
      r_addr <= i_addr;
      r_data <= i_we ? i_wdata : 32'd0;
      r_sel  <= i_sel;
    end
  end

  assign o_done     = r_cyc & i_wbm_ack;
  assign o_rdata    = i_wbm_data;
  assign o_wbm_cyc  = r_cyc;
  assign o_wbm_stb  = r_cyc;
  assign o_wbm_we   = r_we;
  assign o_wbm_addr = r_addr;
  assign o_wbm_data = r_data;
  assign o_wbm_sel  = r_sel;

endmodule

// File: rtl/spi_cmd_seq.sv
// Drives the SPI master core over Wishbone: DIVIDER once, then SS, TX, CTRL+GO, poll GO, read RX.
// Latency: (3 + slave wait states) cycles per bus transfer; 4 transfers + polls (5 on first request).
// Backpressure: req_ready only in IDLE; response held until rsp_ready; poll timeout reports rsp_err.
module spi_cmd_seq
  import spi_regs_pkg::*;
#(
  parameter logic [15:0] DIV_VAL   = 16'd4,
  parameter logic [4:0]  MODE_BITS = 5'b00010,
  parameter int          TIMEOUT   = 4096
) (
  input  logic        wb_clk_in,
  input  logic        wb_rst_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic [6:0]  req_len,
  input  logic [7:0]  req_ss,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [4:0]  wbm_addr_o,
  output logic [31:0] wbm_data_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  seq_state_t  r_state;
  seq_state_t  w_state_nxt;
  logic        r_cfg_done;
  logic [31:0] r_tx;
  logic [6:0]  r_len;
  logic [7:0]  r_ss;
  logic [CW-1:0] r_poll_cnt;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  logic        w_start;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_sel;
  logic        w_done;
  logic [31:0] w_rdata;
  logic        w_timeout;

  spi_wbm_xfer u_xfer (
    .wb_clk_in  (wb_clk_in),
    .wb_rst_in  (wb_rst_in),
    .i_start    (w_start),
    .i_we       (w_we),
    .i_addr     (w_addr),
    .i_wdata    (w_wdata),
    .i_sel      (w_sel),
    .o_done     (w_done),
    .o_rdata    (w_rdata),
    .o_wbm_cyc  (wbm_cyc_o),
    .o_wbm_stb  (wbm_stb_o),
    .o_wbm_we   (wbm_we_o),
    .o_wbm_addr (wbm_addr_o),
    .o_wbm_data (wbm_data_o),
    .o_wbm_sel  (wbm_sel_o),
    .i_wbm_data (wbm_data_i),
    .i_wbm_ack  (wbm_ack_i)
  );

  // State register
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state and the bus transfer each bus state asks the engine for
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_we        = 1'b1;
    w_addr      = ADDR_TX0;
    w_wdata     = 32'd0;
    w_sel       = 4'hF;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_state_nxt = r_cfg_done ? S_WR_SS : S_WR_DIV;
      end
      S_WR_DIV: begin
        w_start = 1'b1;
        w_addr  = ADDR_DIV;
        w_wdata = {16'd0, DIV_VAL};
        if (w_done) w_state_nxt = S_WR_SS;
      end
      S_WR_SS: begin
        // the core copies any selected byte lane into SS, so only lane 0 is enabled
        w_start = 1'b1;
        w_addr  = ADDR_SS;
        w_wdata = {24'd0, r_ss};
        w_sel   = 4'b0001;
        if (w_done) w_state_nxt = S_WR_TX;
      end
      S_WR_TX: begin
        w_start = 1'b1;
        w_addr  = ADDR_TX0;
        w_wdata = r_tx;
        if (w_done) w_state_nxt = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        w_start = 1'b1;
        w_addr  = ADDR_CTRL;
        w_wdata = ctrl_word(MODE_BITS, r_len);
        if (w_done) w_state_nxt = S_POLL;
      end
      S_POLL: begin
        // interrupt is not used: the core clears it on any ack, so GO is the completion flag
        w_start = 1'b1;
        w_we    = 1'b0;
        w_addr  = ADDR_CTRL;
        if (w_done) begin
          if (!w_rdata[CTRL_GO]) begin
            w_state_nxt = S_RD_RX;
          end else if (r_poll_cnt == CW'(TIMEOUT - 1)) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_RSP;
          end
        end
      end
      S_RD_RX: begin
        w_start = 1'b1;
        w_we    = 1'b0;
        w_addr  = ADDR_RX0;
        if (w_done) w_state_nxt = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, one-shot divider flag, poll counter and registered handshake/response outputs
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      r_cfg_done  <= 1'b0;
      r_tx        <= '0;
      r_len       <= '0;
      r_ss        <= '0;
      r_poll_cnt  <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RSP);
      if (r_state == S_IDLE && req_valid) begin
        r_tx  <= req_data;
        r_len <= req_len;
        r_ss  <= req_ss;
      end
      if (r_state == S_WR_DIV && w_done) r_cfg_done <= 1'b1;
      if (r_state == S_WR_CTRL && w_done)   r_poll_cnt <= '0;
      else if (r_state == S_POLL && w_done) r_poll_cnt <= r_poll_cnt + CW'(1);
      if (r_state == S_RD_RX && w_done) begin
        r_rsp_data <= w_rdata;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= 32'd0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Bench for spi_cmd_seq against a behavioural SPI-core Wishbone slave with wait states and GO control.
// Latency: checks request-to-response cycles as (3 + wait states) per expected bus transfer.
// Backpressure: holds rsp_ready low, leaves rsp_ready high while idle, and resets mid-poll.
module tb_spi_cmd_seq;

  localparam int TO = 8;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } xfer_t;

  logic        wb_clk_in = 1'b0;
  logic        wb_rst_in = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = '0;
  logic [6:0]  req_len = '0;
  logic [7:0]  req_ss = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [4:0]  wbm_addr_o;
  logic [31:0] wbm_data_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_data_i = '0;
  logic        wbm_ack_i = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  // slave model controls and state
  int    go_polls = 0;
  bit    stuck = 1'b0;
  int    ws = 0;
  int    wcnt = 0;
  int    gap = 99;
  int    busy = 0;
  logic  ack_prev;
  xfer_t cur;
  logic [31:0] tx_reg = '0, ctrl_reg = '0, div_reg = '0, ss_reg = '0;
  xfer_t log_q[$];
  int    gap_q[$];
  bit    first = 1'b1;
  bit    got_poll;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always #5 wb_clk_in = ~wb_clk_in;

  always @(posedge wb_clk_in) cyc_cnt <= cyc_cnt + 1;

  spi_cmd_seq #(.DIV_VAL(16'd4), .MODE_BITS(5'b00010), .TIMEOUT(TO)) dut (
    .wb_clk_in (wb_clk_in),  .wb_rst_in (wb_rst_in),
    .req_valid (req_valid),  .req_ready (req_ready),
    .req_data  (req_data),   .req_len   (req_len),   .req_ss (req_ss),
    .rsp_valid (rsp_valid),  .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),   .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),  .wbm_stb_o (wbm_stb_o), .wbm_we_o (wbm_we_o),
    .wbm_addr_o(wbm_addr_o), .wbm_data_o(wbm_data_o), .wbm_sel_o(wbm_sel_o),
    .wbm_data_i(wbm_data_i), .wbm_ack_i (wbm_ack_i)
  );

  // SPI core slave model: registered-style ack after ws wait states, GO busy for go_polls reads
  always @(negedge wb_clk_in) begin
    ack_prev  = wbm_ack_i;
    wbm_ack_i = 1'b0;
    if (wb_rst_in) begin
      wcnt = 0;
      gap  = 99;
      busy = 0;
    end else if (!wbm_cyc_o) begin
      gap++;
    end else if (!ack_prev) begin
      chk("stb_with_cyc", wbm_stb_o, 1'b1);
      if (wcnt == 0) begin
        cur = {wbm_we_o, wbm_addr_o, wbm_data_o, wbm_sel_o};
        gap_q.push_back(gap);
        gap = 0;
      end else begin
        chk("bus_held_until_ack", {wbm_we_o, wbm_addr_o, wbm_data_o, wbm_sel_o}, cur);
      end
      if (wcnt == ws + 1) begin
        wcnt = 0;
        wbm_ack_i = 1'b1;
        if (cur.we) begin
          case (cur.addr)
            5'h00: tx_reg = cur.data;
            5'h10: begin ctrl_reg = cur.data; busy = go_polls; end
            5'h14: div_reg = cur.data;
            5'h18: ss_reg = cur.data;
            default: ;
          endcase
        end else if (cur.addr == 5'h10) begin
          wbm_data_i    = ctrl_reg;
          wbm_data_i[8] = stuck || (busy > 0);
          if (busy > 0) busy--;
        end else begin
          wbm_data_i = tx_reg;
        end
        log_q.push_back({cur.we, cur.addr, cur.we ? cur.data : 32'd0, cur.sel});
      end else begin
        wcnt++;
      end
    end
  end

  function automatic xfer_t mk(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    mk = {we, a, d, s};
  endfunction

  task automatic do_req(input logic [31:0] d, input logic [6:0] len, input logic [7:0] ss,
                        input int bp, input bit stk, input int wsv, input int hold, input bit rdy_early);
    xfer_t exp_q[$];
    int nreads, ntr, t0;
    bit got;
    logic [31:0] exp_data;
    go_polls = bp; stuck = stk; ws = wsv;
    log_q.delete(); gap_q.delete();
    @(negedge wb_clk_in);
    if (rdy_early) rsp_ready = 1'b1;
    req_data = d; req_len = len; req_ss = ss; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1'b1);
    @(negedge wb_clk_in);
    req_valid = 1'b0;
    t0 = cyc_cnt;
    chk("req_ready_drop", req_ready, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else @(negedge wb_clk_in);
    end
    chk("rsp_arrived", got, 1'b1);
    if (!got) return;
    // reference: expected bus script and response from the register-programming rules
    nreads   = stk ? TO : bp + 1;
    exp_data = stk ? 32'd0 : d;
    if (first) exp_q.push_back(mk(1'b1, 5'h14, 32'h0000_0004, 4'hF));
    exp_q.push_back(mk(1'b1, 5'h18, {24'd0, ss}, 4'h1));
    exp_q.push_back(mk(1'b1, 5'h00, d, 4'hF));
    exp_q.push_back(mk(1'b1, 5'h10, 32'h0000_0400 | 32'h0000_0100 | {25'd0, len}, 4'hF));
    for (int i = 0; i < nreads; i++) exp_q.push_back(mk(1'b0, 5'h10, 32'd0, 4'hF));
    if (!stk) exp_q.push_back(mk(1'b0, 5'h00, 32'd0, 4'hF));
    ntr = exp_q.size();
    chk("latency", cyc_cnt - t0, (3 + wsv) * ntr);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", rsp_err, stk);
    for (int i = 0; i < hold; i++) begin
      @(negedge wb_clk_in);
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_data", rsp_data, exp_data);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_in);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 1'b0);
    chk("req_ready_after_hs", req_ready, 1'b1);
    chk("xfer_count", log_q.size(), ntr);
    for (int k = 0; k < ntr && k < log_q.size(); k++) begin
      chk("xfer_entry", log_q[k], exp_q[k]);
      if (k > 0) chk("idle_gap", gap_q[k], 1);
    end
    first = 1'b0;
  endtask

  initial begin
    @(negedge wb_clk_in);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp", {rsp_valid, rsp_data, rsp_err}, 34'd0);
    chk("rst_wbm", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_data_o, wbm_sel_o}, 44'd0);
    @(negedge wb_clk_in);
    wb_rst_in = 1'b0;

    // first request: divider write, loopback result
    do_req(32'hA5A5_0F0F, 7'd32, 8'h01, 2, 1'b0, 0, 0, 1'b0);
    // second request: no divider, response held off for 10 cycles
    do_req($urandom, 7'($urandom_range(0, 127)), 8'($urandom), 1, 1'b0, 0, 10, 1'b0);
    // GO never clears: TO polls then error response
    do_req(32'hDEAD_BEEF, 7'd0, 8'h80, 0, 1'b1, 0, 0, 1'b0);
    // last poll before the limit sees GO clear: success, not timeout
    do_req(32'h1234_5678, 7'd8, 8'h02, TO - 1, 1'b0, 0, 0, 1'b0);
    // three wait states per transfer
    do_req(32'h0F0F_F0F0, 7'd16, 8'h04, 3, 1'b0, 3, 0, 1'b0);
    // randomized requests, rsp_ready sometimes high while idle
    for (int r = 0; r < 6; r++)
      do_req($urandom, 7'($urandom_range(0, 127)), 8'($urandom), int'($urandom_range(0, 6)),
             1'b0, int'($urandom_range(0, 3)), 0, r[0]);

    // reset while polling a stuck core
    stuck = 1'b1; go_polls = 0; ws = 0;
    @(negedge wb_clk_in);
    req_data = 32'h5555_AAAA; req_len = 7'd32; req_ss = 8'h01; req_valid = 1'b1;
    @(negedge wb_clk_in);
    req_valid = 1'b0;
    got_poll = 1'b0;
    for (int i = 0; i < 500 && !got_poll; i++) begin
      @(negedge wb_clk_in);
      if (wbm_cyc_o && !wbm_we_o && wbm_addr_o == 5'h10) got_poll = 1'b1;
    end
    chk("poll_reached", got_poll, 1'b1);
    #2 wb_rst_in = 1'b1;
    #1;
    chk("async_wbm_clear", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o, wbm_data_o, wbm_sel_o}, 44'd0);
    chk("async_handshake", {req_ready, rsp_valid}, 2'b10);
    @(negedge wb_clk_in);
    @(negedge wb_clk_in);
    wb_rst_in = 1'b0;
    stuck = 1'b0;
    first = 1'b1;
    @(negedge wb_clk_in);
    chk("no_rsp_after_reset", rsp_valid, 1'b0);
    do_req($urandom, 7'd32, 8'h10, 1, 1'b0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
